// File: rtl/icache_fill_unit_pkg.sv
// rtl/icache_fill_unit_pkg.sv - shared constants and state encoding for the icache fill unit
//
// Contents:
//   ICACHE_SIZE_BIT  log2 of the instruction cache size in words
//   BYTES_PER_WORD   bytes fetched from the byte-wide memory port per miss
//   state_t          fill FSM encoding (IDLE, REQ, BURST, WRITE)

package icache_fill_unit_pkg;

    localparam int ICACHE_SIZE_BIT = 8;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/icache_fill_unit_if.sv
// rtl/icache_fill_unit_if.sv - fetch, cache and memory-arbiter signal bundle of the fill unit
//
// Signals:
//   fetch_valid_in/fetch_pc_in/fetch_ready_out      fetch request handshake
//   resp_valid_out/resp_inst_out/resp_pc_out        instruction response
//   cache_addr_out/cache_hit_in/cache_data_in       cache lookup
//   cache_we_out/cache_wdata_out                    cache fill write
//   mem_req_out/mem_gnt_in/mem_addr_out/mem_data_in byte-wide memory arbiter port
// Modports:
//   master  the fill unit
//   slave   fetch stage, cache and arbiter side

interface icache_fill_unit_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid_in;
    logic [ADDR_W-1:0] fetch_pc_in;
    logic              fetch_ready_out;
    logic              resp_valid_out;
    logic [31:0]       resp_inst_out;
    logic [ADDR_W-1:0] resp_pc_out;
    logic [ADDR_W-1:0] cache_addr_out;
    logic              cache_hit_in;
    logic [31:0]       cache_data_in;
    logic              cache_we_out;
    logic [31:0]       cache_wdata_out;
    logic              mem_req_out;
    logic              mem_gnt_in;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [7:0]        mem_data_in;

    modport master (
        input  fetch_valid_in, fetch_pc_in, cache_hit_in, cache_data_in,
               mem_gnt_in, mem_data_in,
        output fetch_ready_out, resp_valid_out, resp_inst_out, resp_pc_out,
               cache_addr_out, cache_we_out, cache_wdata_out,
               mem_req_out, mem_addr_out
    );

    modport slave (
        output fetch_valid_in, fetch_pc_in, cache_hit_in, cache_data_in,
               mem_gnt_in, mem_data_in,
        input  fetch_ready_out, resp_valid_out, resp_inst_out, resp_pc_out,
               cache_addr_out, cache_we_out, cache_wdata_out,
               mem_req_out, mem_addr_out
    );

endinterface

// File: rtl/icache_fill_unit_byte_assembler.sv
// rtl/icache_fill_unit_byte_assembler.sv - receive counter and little-endian word buffer for a miss burst
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           global enable; nothing updates while low
//   clear        drop the partial word and restart at byte 0
//   recv         mem byte on data is valid this cycle
//   data         received byte
//   word         assembled word, byte k in bits [8k+7:8k]
//   count        bytes received so far (0..BYTES_PER_WORD)
//   last         the byte being received now completes the word
//   done         all bytes of the word have been received

module icache_fill_unit_byte_assembler
    import icache_fill_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clear,
    input  logic        recv,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [2:0]  count,
    output logic        last,
    output logic        done
);

    assign done = (count == 3'(BYTES_PER_WORD));
    assign last = recv && (count == 3'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            count <= '0;
        end else if (en) begin
            if (clear) begin
                word  <= '0;
                count <= '0;
            end else if (recv && !done) begin
                word[{count[1:0], 3'b000} +: 8] <= data;
                count                           <= count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/icache_fill_unit.sv
// rtl/icache_fill_unit.sv - instruction-cache fill unit: hit responses and byte-wise miss refill
//
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   rdy_in             global enable; all state freezes while low
//   flush_in           fetch redirect; aborts any outstanding request or response
//   bus                icache_fill_unit_if.master (fetch, response, cache and memory signals)
//   perf_hit_cnt_out   accepted hits   (only with ICACHE_PERF_EN defined)
//   perf_miss_cnt_out  accepted misses (only with ICACHE_PERF_EN defined)
// Build option: ICACHE_PERF_EN adds the hit/miss performance counters.

module icache_fill_unit #(
    parameter int ADDR_W         = 32,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
`ifdef ICACHE_PERF_EN
    output logic [31:0]         perf_hit_cnt_out,
    output logic [31:0]         perf_miss_cnt_out,
`endif
    icache_fill_unit_if.master  bus
);

    import icache_fill_unit_pkg::state_t;
    import icache_fill_unit_pkg::IDLE;
    import icache_fill_unit_pkg::REQ;
    import icache_fill_unit_pkg::BURST;
    import icache_fill_unit_pkg::WRITE;

    if (BYTES_PER_WORD != 4) begin : g_bpw_check
        $error("icache_fill_unit supports only BYTES_PER_WORD == 4");
    end

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] miss_pc;
    logic [2:0]        issue_cnt;
    logic              hit_q;
    logic [31:0]       hit_inst;
    logic [ADDR_W-1:0] hit_pc;

    logic              accept, accept_hit, accept_miss;
    logic              issue, recv, clear, last, done;
    logic [2:0]        recv_cnt;
    logic [31:0]       word;

    assign accept      = (state == IDLE) && bus.fetch_valid_in && !flush_in;
    assign accept_hit  = accept && bus.cache_hit_in;
    assign accept_miss = accept && !bus.cache_hit_in;

    // One address goes out per BURST cycle; a byte is owed back whenever more
    // addresses have been issued than bytes received.
    assign issue = (state == BURST) && (issue_cnt < 3'(BYTES_PER_WORD));
    assign recv  = (state == BURST) && (issue_cnt != recv_cnt) && !done;
    assign clear = flush_in || (state == WRITE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_miss)    state_nxt = REQ;
            REQ:     if (bus.mem_gnt_in) state_nxt = BURST;
            BURST:   if (last)           state_nxt = WRITE;
            WRITE:                       state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
        if (flush_in) state_nxt = IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            miss_pc   <= '0;
            issue_cnt <= '0;
            hit_q     <= 1'b0;
            hit_inst  <= '0;
            hit_pc    <= '0;
        end else if (rdy_in) begin
            state <= state_nxt;
            hit_q <= accept_hit;
            if (accept_hit) begin
                hit_inst <= bus.cache_data_in;
                hit_pc   <= bus.fetch_pc_in;
            end
            if (accept_miss) miss_pc <= bus.fetch_pc_in;
            if (clear)       issue_cnt <= '0;
            else if (issue)  issue_cnt <= issue_cnt + 3'd1;
        end
    end

    icache_fill_unit_byte_assembler u_asm (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (rdy_in),
        .clear (clear),
        .recv  (recv),
        .data  (bus.mem_data_in),
        .word  (word),
        .count (recv_cnt),
        .last  (last),
        .done  (done)
    );

    assign bus.fetch_ready_out = (state == IDLE);
    assign bus.cache_addr_out  = (state == IDLE) ? bus.fetch_pc_in : miss_pc;
    assign bus.resp_valid_out  = (hit_q || (state == WRITE)) && !flush_in;
    assign bus.resp_inst_out   = (state == WRITE) ? word : hit_inst;
    assign bus.resp_pc_out     = (state == WRITE) ? miss_pc : hit_pc;
    assign bus.cache_we_out    = (state == WRITE) && !flush_in;
    assign bus.cache_wdata_out = (state == WRITE) ? word : 32'd0;
    assign bus.mem_req_out     = (state == REQ) || (state == BURST);
    // Byte 0 is already on the address bus while waiting for the grant.
    assign bus.mem_addr_out    = ((state == REQ) || issue) ? miss_pc + ADDR_W'(issue_cnt) : '0;

    assert property (@(posedge clk_in) disable iff (!rst_n_in)
                     (state == BURST && !flush_in) |-> bus.mem_gnt_in)
        else $error("mem_gnt_in dropped during a burst");

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_hit_cnt_out  <= '0;
            perf_miss_cnt_out <= '0;
        end else if (rdy_in) begin
            if (accept_hit)  perf_hit_cnt_out  <= perf_hit_cnt_out + 32'd1;
            if (accept_miss) perf_miss_cnt_out <= perf_miss_cnt_out + 32'd1;
        end
    end
`endif

endmodule
